// File: rtl/switch_panel_sequencer.sv
// Drives the processor wrapper's switch/button interface as an operator would:
// each queued 32-bit instruction becomes four button presses (low half, high
// half, result-low readout, result-high readout) and one 32-bit response.
module switch_panel_sequencer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned SETUP_CYC  = 2,
    parameter int unsigned PRESS_CYC  = 2,
    parameter int unsigned GAP_CYC    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cmd_data,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    output logic [15:0] sw_in,
    output logic        sw_btn,
    input  logic [15:0] led_in,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        busy
);

    localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
    localparam int unsigned MaxCyc = (SETUP_CYC > PRESS_CYC) ?
                                     ((SETUP_CYC > GAP_CYC) ? SETUP_CYC : GAP_CYC) :
                                     ((PRESS_CYC > GAP_CYC) ? PRESS_CYC : GAP_CYC);
    localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

    localparam logic [CntW-1:0] SetupLast = CntW'(SETUP_CYC - 1);
    localparam logic [CntW-1:0] PressLast = CntW'(PRESS_CYC - 1);
    localparam logic [CntW-1:0] GapLast   = CntW'(GAP_CYC - 1);
    localparam logic [PtrW:0]   FullCnt   = (PtrW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {StIdle, StSetup, StPress, StGap, StCheck, StResp} state_e;

    logic [31:0]     fifo_mem [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [PtrW:0]   count_q;
    logic            push;
    logic            pop;

    state_e          state_q;
    logic [1:0]      phase_q;
    logic [CntW-1:0] cnt_q;
    logic [31:0]     word_q;
    logic [15:0]     result_lo_q;
    logic            err_q;

    assign cmd_ready = (count_q != FullCnt);
    assign push      = cmd_valid && cmd_ready;
    // Pops happen only from IDLE, so nothing leaves the FIFO while a response waits.
    assign pop       = (state_q == StIdle) && (count_q != '0);
    assign busy      = (state_q != StIdle) || (count_q != '0);

    // Command storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= cmd_data;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave occupancy unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + (PtrW + 1)'(1);
            end else if (!push && pop) begin
                count_q <= count_q - (PtrW + 1)'(1);
            end
        end
    end

    // Press sequencer with registered switch, button and response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            phase_q     <= 2'd0;
            cnt_q       <= '0;
            word_q      <= '0;
            result_lo_q <= '0;
            err_q       <= 1'b0;
            sw_in       <= '0;
            sw_btn      <= 1'b0;
            rsp_data    <= '0;
            rsp_err     <= 1'b0;
            rsp_valid   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pop) begin
                        word_q  <= fifo_mem[rd_ptr_q];
                        sw_in   <= fifo_mem[rd_ptr_q][15:0];
                        phase_q <= 2'd0;
                        err_q   <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= StSetup;
                    end
                end
                StSetup: begin
                    if (cnt_q == SetupLast) begin
                        cnt_q   <= '0;
                        sw_btn  <= 1'b1;
                        state_q <= StPress;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StPress: begin
                    if (cnt_q == PressLast) begin
                        cnt_q   <= '0;
                        sw_btn  <= 1'b0;
                        state_q <= StGap;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StGap: begin
                    if (cnt_q == GapLast) begin
                        cnt_q   <= '0;
                        state_q <= StCheck;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StCheck: begin
                    // Ack mismatches only flag the error; all four presses always run
                    // so the target's phase counter stays aligned.
                    case (phase_q)
                        2'd0: if (led_in != 16'd1) err_q <= 1'b1;
                        2'd1: if (led_in != 16'd2) err_q <= 1'b1;
                        2'd2: result_lo_q <= led_in;
                        2'd3: ;
                    endcase
                    if (phase_q == 2'd3) begin
                        rsp_data  <= {led_in, result_lo_q};
                        rsp_err   <= err_q;
                        rsp_valid <= 1'b1;
                        state_q   <= StResp;
                    end else begin
                        phase_q <= phase_q + 2'd1;
                        sw_in   <= (phase_q == 2'd0) ? word_q[31:16] : 16'd0;
                        state_q <= StSetup;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
